// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - two-flop synchronised switch debouncer with edge pulses and press counter

module debounce_edge #(
   parameter int STABLE_CYCLES = 4,
   parameter int EVT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_clear_n,
   input  logic             i_data,
   output logic             o_level,
   output logic             o_rise,
   output logic             o_fall,
   output logic [EVT_W-1:0] o_press_cnt
);

   // Counter only needs to reach STABLE_CYCLES-1; guard keeps the width legal
   // while the elaboration check below reports an illegal setting.
   localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
         $error("debounce_edge: STABLE_CYCLES must be 1 or more");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_WAIT_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_WAIT_L = 2'd3
   } state_t;

   logic             s1;
   logic             s2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             level_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
   logic [EVT_W-1:0] press_nxt;

   // Two-flop synchroniser; only s2 is allowed to reach the FSM.
   always_ff @(posedge i_clk or negedge i_clear_n) begin
      if (!i_clear_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= i_data;
         s2 <= s1;
      end
   end

   // FSM state, stability counter and all outputs are registered together.
   always_ff @(posedge i_clk or negedge i_clear_n) begin
      if (!i_clear_n) begin
         state       <= ST_LOW;
         cnt         <= '0;
         o_level     <= 1'b0;
         o_rise      <= 1'b0;
         o_fall      <= 1'b0;
         o_press_cnt <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         o_level     <= level_nxt;
         o_rise      <= rise_nxt;
         o_fall      <= fall_nxt;
         o_press_cnt <= press_nxt;
      end
   end

   // Next-state: a WAIT state must see the new level on CNT_LAST+1 further
   // samples; any sample of the old level drops back with no visible change.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = o_level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      press_nxt = o_press_cnt;
      case (state)
         ST_LOW: begin
            if (s2) begin
               state_nxt = ST_WAIT_H;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_H: begin
            if (!s2) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
               press_nxt = o_press_cnt + EVT_W'(1);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!s2) begin
               state_nxt = ST_WAIT_L;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_L: begin
            if (s2) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - scoreboard bench for debounce_edge

`timescale 1ns/1ps

module tb_debounce_edge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       clr_a = 1'b0, data_a = 1'b0;
   logic       clr_s = 1'b0, data_s = 1'b0;
   logic       a_level, a_rise, a_fall;
   logic [7:0] a_cnt;
   logic       w_level, w_rise, w_fall;
   logic [1:0] w_cnt;
   logic       s_level, s_rise, s_fall;
   logic [7:0] s_cnt;

   int checks   = 0;
   int failures = 0;
   bit done_s   = 1'b0;

   typedef struct {
      int cyc;
      bit rise;
      int cnt;
   } ev_t;

   ev_t q_a[$];
   ev_t q_w[$];
   ev_t q_s[$];

   debounce_edge #(.STABLE_CYCLES(4), .EVT_W(8)) dut_a (
      .i_clk(clk), .i_clear_n(clr_a), .i_data(data_a),
      .o_level(a_level), .o_rise(a_rise), .o_fall(a_fall), .o_press_cnt(a_cnt));

   debounce_edge #(.STABLE_CYCLES(4), .EVT_W(2)) dut_w (
      .i_clk(clk), .i_clear_n(clr_a), .i_data(data_a),
      .o_level(w_level), .o_rise(w_rise), .o_fall(w_fall), .o_press_cnt(w_cnt));

   debounce_edge #(.STABLE_CYCLES(1), .EVT_W(8)) dut_s (
      .i_clk(clk), .i_clear_n(clr_s), .i_data(data_s),
      .o_level(s_level), .o_rise(s_rise), .o_fall(s_fall), .o_press_cnt(s_cnt));

   function automatic ev_t mk(input int c, input bit r, input int n);
      ev_t e;
      e.cyc  = c;
      e.rise = r;
      e.cnt  = n;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic chk_ev(input string name, input ev_t e, input int c,
                         input logic r, input logic f, input logic lv, input int n);
      checks++;
      if (c != e.cyc || r !== e.rise || f !== !e.rise || lv !== e.rise || n != e.cnt) begin
         failures++;
         $display("FAIL %s actual cyc=%0d rise=%0b fall=%0b level=%0b cnt=%0d required cyc=%0d rise=%0b fall=%0b level=%0b cnt=%0d",
                  name, c, r, f, lv, n, e.cyc, e.rise, !e.rise, e.rise, e.cnt);
      end
   endtask

   // Expected events for the two STABLE_CYCLES=4 instances sharing stimulus.
   task automatic expect_ev(input int at, input bit r, input int presses);
      q_a.push_back(mk(at, r, presses % 256));
      q_w.push_back(mk(at, r, presses % 4));
   endtask

   // Monitors: every pulse must match the head of its queue; a head whose
   // cycle has passed without a pulse is a missing event.
   always @(negedge clk) begin
      ev_t e;
      if (a_rise || a_fall) begin
         if (q_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_pulse cyc=%0d rise=%0b fall=%0b required no pulse", cyc, a_rise, a_fall);
         end else begin
            e = q_a.pop_front();
            chk_ev("a_event", e, cyc, a_rise, a_fall, a_level, int'(a_cnt));
         end
      end else if (q_a.size() > 0 && cyc > q_a[0].cyc) begin
         e = q_a.pop_front();
         checks++; failures++;
         $display("FAIL a_missing_pulse cyc=%0d actual none required rise=%0b at cyc=%0d", cyc, e.rise, e.cyc);
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (w_rise || w_fall) begin
         if (q_w.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_unexpected_pulse cyc=%0d rise=%0b fall=%0b required no pulse", cyc, w_rise, w_fall);
         end else begin
            e = q_w.pop_front();
            chk_ev("w_event", e, cyc, w_rise, w_fall, w_level, int'(w_cnt));
         end
      end else if (q_w.size() > 0 && cyc > q_w[0].cyc) begin
         e = q_w.pop_front();
         checks++; failures++;
         $display("FAIL w_missing_pulse cyc=%0d actual none required rise=%0b at cyc=%0d", cyc, e.rise, e.cyc);
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (s_rise || s_fall) begin
         if (q_s.size() == 0) begin
            checks++; failures++;
            $display("FAIL s_unexpected_pulse cyc=%0d rise=%0b fall=%0b required no pulse", cyc, s_rise, s_fall);
         end else begin
            e = q_s.pop_front();
            chk_ev("s_event", e, cyc, s_rise, s_fall, s_level, int'(s_cnt));
         end
      end else if (q_s.size() > 0 && cyc > q_s[0].cyc) begin
         e = q_s.pop_front();
         checks++; failures++;
         $display("FAIL s_missing_pulse cyc=%0d actual none required rise=%0b at cyc=%0d", cyc, e.rise, e.cyc);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_a(input logic v, output int c);
      @(negedge clk);
      data_a = v;
      c = cyc;
   endtask

   // STABLE_CYCLES=1 instance: data high through reset, short glitches.
   initial begin
      int c0;
      clr_s  = 1'b0;
      data_s = 1'b1;
      idle(3);
      chk("s_reset_level", s_level, 0);
      chk("s_reset_cnt", int'(s_cnt), 0);
      @(negedge clk);
      clr_s = 1'b1;
      c0 = cyc;
      q_s.push_back(mk(c0 + 4, 1'b1, 1));
      idle(8);
      @(negedge clk) data_s = 1'b0;
      @(negedge clk) data_s = 1'b1;
      idle(8);
      chk("s_glitch1_level", s_level, 1);
      @(negedge clk);
      data_s = 1'b0;
      c0 = cyc;
      q_s.push_back(mk(c0 + 4, 1'b0, 1));
      q_s.push_back(mk(c0 + 6, 1'b1, 2));
      @(negedge clk);
      @(negedge clk) data_s = 1'b1;
      idle(10);
      chk("s_final_cnt", int'(s_cnt), 2);
      done_s = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual timeout required finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int presses;
      int pat[6];
      pat = '{1, 0, 1, 1, 0, 1};
      presses = 0;
      clr_a  = 1'b0;
      data_a = 1'b0;
      idle(3);
      chk("a_reset_level", a_level, 0);
      chk("a_reset_rise", a_rise, 0);
      chk("a_reset_fall", a_fall, 0);
      chk("a_reset_cnt", int'(a_cnt), 0);
      chk("w_reset_cnt", int'(w_cnt), 0);
      @(negedge clk) clr_a = 1'b1;
      idle(3);

      // clean step
      drive_a(1'b1, c0);
      presses++;
      expect_ev(c0 + 7, 1'b1, presses);
      idle(12);
      chk("step_level", a_level, 1);
      chk("step_cnt", int'(a_cnt), 1);

      // release
      drive_a(1'b0, c0);
      expect_ev(c0 + 7, 1'b0, presses);
      idle(12);
      chk("release_level", a_level, 0);
      chk("release_cnt", int'(a_cnt), 1);

      // 4-cycle glitch rejected
      drive_a(1'b1, c0);
      repeat (4) @(negedge clk);
      data_a = 1'b0;
      idle(12);
      chk("glitch4_level", a_level, 0);
      chk("glitch4_cnt", int'(a_cnt), 1);

      // 5-cycle pulse accepted, then released
      drive_a(1'b1, c0);
      presses++;
      expect_ev(c0 + 7, 1'b1, presses);
      expect_ev(c0 + 12, 1'b0, presses);
      repeat (5) @(negedge clk);
      data_a = 1'b0;
      idle(14);
      chk("pulse5_cnt", int'(a_cnt), 2);

      // bounce 1,0,1,1,0,1 then steady 1
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         data_a = pat[i][0];
         if (i == 0) c0 = cyc;
      end
      presses++;
      expect_ev(c0 + 12, 1'b1, presses);
      idle(12);
      chk("bounce_level", a_level, 1);

      // fast toggling from HIGH holds the level
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         data_a = ~data_a;
      end
      idle(10);
      chk("toggle_level", a_level, 1);
      chk("toggle_cnt", int'(a_cnt), 3);

      // two more presses wrap the 2-bit counter
      for (int k = 0; k < 2; k++) begin
         drive_a(1'b0, c0);
         expect_ev(c0 + 7, 1'b0, presses);
         idle(10);
         drive_a(1'b1, c0);
         presses++;
         expect_ev(c0 + 7, 1'b1, presses);
         idle(10);
      end
      chk("wrap_w_cnt", int'(w_cnt), 1);
      chk("wrap_a_cnt", int'(a_cnt), 5);

      // reset in WAIT_H aborts the transition
      drive_a(1'b0, c0);
      expect_ev(c0 + 7, 1'b0, presses);
      idle(10);
      drive_a(1'b1, c0);
      repeat (5) @(negedge clk);
      clr_a = 1'b0;
      #1;
      chk("midrst_level", a_level, 0);
      chk("midrst_rise", a_rise, 0);
      chk("midrst_cnt", int'(a_cnt), 0);
      chk("midrst_w_cnt", int'(w_cnt), 0);
      idle(2);
      @(negedge clk);
      clr_a = 1'b1;
      c0 = cyc;
      presses = 1;
      expect_ev(c0 + 7, 1'b1, presses);
      idle(12);
      chk("post_rst_cnt", int'(a_cnt), 1);
      chk("post_rst_level", a_level, 1);

      for (int i = 0; i < 200 && !done_s; i++) @(negedge clk);
      chk("s_done", int'(done_s), 1);
      idle(2);
      chk("q_a_empty", q_a.size(), 0);
      chk("q_w_empty", q_w.size(), 0);
      chk("q_s_empty", q_s.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
